// File: rtl/dtfag_pkg.sv
// rtl/dtfag_pkg.sv - shared widths, limits and FSM encoding for the twiddle index sequencer
package dtfag_pkg;

    localparam int RADIX_W   = 4;
    localparam int DIGITS    = 3;
    localparam int CNT_W     = RADIX_W * DIGITS;
    localparam int TW_STAGES = 3;
    localparam int STAGE_W   = 2;

    localparam logic [CNT_W-1:0]   LAST_CNT   = 12'hFFF;
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(TW_STAGES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/dtfag_idx_seq_if.sv
// rtl/dtfag_idx_seq_if.sv - control and issue bundle of the sequencer (inv port exists with DTFAG_SEQ_INV_EN)
interface dtfag_idx_seq_if;
    import dtfag_pkg::*;

    logic                 start;
    logic                 stall;
`ifdef DTFAG_SEQ_INV_EN
    logic                 inv;
`endif
    logic                 busy;
    logic                 done;
    logic                 ROM_CEN;
    logic [RADIX_W-1:0]   DTFAG_j;
    logic [RADIX_W-1:0]   DTFAG_t;
    logic [RADIX_W-1:0]   DTFAG_i;
    logic [STAGE_W-1:0]   stage_o;
    logic [CNT_W-1:0]     grp_o;

`ifdef DTFAG_SEQ_INV_EN
    modport master (
        input  start, stall, inv,
        output busy, done, ROM_CEN, DTFAG_j, DTFAG_t, DTFAG_i, stage_o, grp_o
    );
    modport slave (
        output start, stall, inv,
        input  busy, done, ROM_CEN, DTFAG_j, DTFAG_t, DTFAG_i, stage_o, grp_o
    );
`else
    modport master (
        input  start, stall,
        output busy, done, ROM_CEN, DTFAG_j, DTFAG_t, DTFAG_i, stage_o, grp_o
    );
    modport slave (
        output start, stall,
        input  busy, done, ROM_CEN, DTFAG_j, DTFAG_t, DTFAG_i, stage_o, grp_o
    );
`endif

endinterface

// File: rtl/dtfag_digit_map.sv
// rtl/dtfag_digit_map.sv - (stage, cnt[, inv]) to exponent digits j/t/i; inv input with DTFAG_SEQ_INV_EN
module dtfag_digit_map
    import dtfag_pkg::*;
(
    input  logic [STAGE_W-1:0] stage,
    input  logic [CNT_W-1:0]   cnt,
`ifdef DTFAG_SEQ_INV_EN
    input  logic               inv,
`endif
    output logic [RADIX_W-1:0] j,
    output logic [RADIX_W-1:0] t,
    output logic [RADIX_W-1:0] i
);

    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] e;

    // Shifting left and truncating to CNT_W bits keeps only the low stage+1 digits.
    always_comb begin
        x = cnt;
        if (stage == 2'd0) begin
            x = cnt << (2 * RADIX_W);
        end else if (stage == 2'd1) begin
            x = cnt << RADIX_W;
        end
    end

`ifdef DTFAG_SEQ_INV_EN
    assign e = inv ? ({CNT_W{1'b0}} - x) : x;
`else
    assign e = x;
`endif

    assign j = e[3*RADIX_W-1:2*RADIX_W];
    assign t = e[2*RADIX_W-1:RADIX_W];
    assign i = e[RADIX_W-1:0];

endmodule

// File: rtl/dtfag_idx_seq.sv
// rtl/dtfag_idx_seq.sv - stage/group sequencer issuing twiddle ROM digit triples (inverse option DTFAG_SEQ_INV_EN)
module dtfag_idx_seq
    import dtfag_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    dtfag_idx_seq_if.master  bus
);

    state_t               state_q, state_d;
    logic [STAGE_W-1:0]   stage_q, stage_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 fin_q, fin_d;
    logic                 replay_q, replay_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 rom_cen_q, rom_cen_d;
    logic [RADIX_W-1:0]   j_q, j_d;
    logic [RADIX_W-1:0]   t_q, t_d;
    logic [RADIX_W-1:0]   i_q, i_d;
    logic [STAGE_W-1:0]   stage_o_q, stage_o_d;
    logic [CNT_W-1:0]     grp_q, grp_d;
`ifdef DTFAG_SEQ_INV_EN
    logic                 inv_q, inv_d;
`endif

    logic [RADIX_W-1:0]   map_j, map_t, map_i;

    dtfag_digit_map u_map (
        .stage (stage_q),
        .cnt   (cnt_q),
`ifdef DTFAG_SEQ_INV_EN
        .inv   (inv_q),
`endif
        .j     (map_j),
        .t     (map_t),
        .i     (map_i)
    );

    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        cnt_d     = cnt_q;
        fin_d     = fin_q;
        replay_d  = replay_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rom_cen_d = rom_cen_q;
        j_d       = j_q;
        t_d       = t_q;
        i_d       = i_q;
        stage_o_d = stage_o_q;
        grp_d     = grp_q;
`ifdef DTFAG_SEQ_INV_EN
        inv_d     = inv_q;
`endif
        unique case (state_q)
            IDLE: begin
                rom_cen_d = 1'b1;
                if (bus.start) begin
                    state_d  = RUN;
                    stage_d  = '0;
                    cnt_d    = '0;
                    fin_d    = 1'b0;
                    replay_d = 1'b0;
`ifdef DTFAG_SEQ_INV_EN
                    inv_d    = bus.inv;
`endif
                end
            end
            RUN: begin
                if (bus.stall) begin
                    // A triple shown while stalled was not consumed; remember to show it again.
                    rom_cen_d = 1'b1;
                    if (!rom_cen_q) begin
                        replay_d = 1'b1;
                    end
                end else if (replay_q) begin
                    rom_cen_d = 1'b0;
                    replay_d  = 1'b0;
                end else if (fin_q) begin
                    state_d   = DONE;
                    rom_cen_d = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end else begin
                    rom_cen_d = 1'b0;
                    busy_d    = 1'b1;
                    j_d       = map_j;
                    t_d       = map_t;
                    i_d       = map_i;
                    stage_o_d = stage_q;
                    grp_d     = cnt_q;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        if (stage_q == LAST_STAGE) begin
                            fin_d = 1'b1;
                        end else begin
                            stage_d = stage_q + 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                rom_cen_d = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            stage_q   <= '0;
            cnt_q     <= '0;
            fin_q     <= 1'b0;
            replay_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rom_cen_q <= 1'b1;
            j_q       <= '0;
            t_q       <= '0;
            i_q       <= '0;
            stage_o_q <= '0;
            grp_q     <= '0;
`ifdef DTFAG_SEQ_INV_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            cnt_q     <= cnt_d;
            fin_q     <= fin_d;
            replay_q  <= replay_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rom_cen_q <= rom_cen_d;
            j_q       <= j_d;
            t_q       <= t_d;
            i_q       <= i_d;
            stage_o_q <= stage_o_d;
            grp_q     <= grp_d;
`ifdef DTFAG_SEQ_INV_EN
            inv_q     <= inv_d;
`endif
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.ROM_CEN = rom_cen_q;
    assign bus.DTFAG_j = j_q;
    assign bus.DTFAG_t = t_q;
    assign bus.DTFAG_i = i_q;
    assign bus.stage_o = stage_o_q;
    assign bus.grp_o   = grp_q;

endmodule

// File: tb/tb_dtfag_idx_seq.sv
// tb/tb_dtfag_idx_seq.sv - scoreboard bench for dtfag_idx_seq (exercises inv when DTFAG_SEQ_INV_EN is defined)
module tb_dtfag_idx_seq;
    import dtfag_pkg::*;

    typedef struct packed {
        logic [1:0]  stage;
        logic [11:0] grp;
        logic [3:0]  j;
        logic [3:0]  t;
        logic [3:0]  i;
    } iss_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dtfag_idx_seq_if ifc ();

    dtfag_idx_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.master)
    );

    always #5 clk = ~clk;

    int   tests = 0;
    int   fails = 0;
    iss_t exp_q[$];
    iss_t last_seen;
    bit   last_valid = 1'b0;
    bit   mon_en = 1'b0;
    int   accepted = 0;
    int   cen0_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Exponent straight from the definition: low s+1 digits of the counter, moved to the top.
    function automatic iss_t model(input int s, input int c, input bit inv_b);
        iss_t r;
        int   x;
        x = (c % (16 ** (s + 1))) * (16 ** (2 - s));
        if (inv_b) x = (4096 - x) % 4096;
        r.stage = 2'(s);
        r.grp   = 12'(c);
        r.j     = 4'(x / 256);
        r.t     = 4'((x / 16) % 16);
        r.i     = 4'(x % 16);
        return r;
    endfunction

    function automatic iss_t dut_iss();
        iss_t r;
        r.stage = ifc.stage_o;
        r.grp   = ifc.grp_o;
        r.j     = ifc.DTFAG_j;
        r.t     = ifc.DTFAG_t;
        r.i     = ifc.DTFAG_i;
        return r;
    endfunction

    // Monitor: a shown triple is consumed only when stall is low at the following edge.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (ifc.ROM_CEN == 1'b0) begin
                cen0_cycles++;
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", 32'(dut_iss()), 32'hFFFF_FFFF);
                end else begin
                    check("issue", 32'(dut_iss()), 32'(exp_q[0]));
                    last_seen  = dut_iss();
                    last_valid = 1'b1;
                    if (!ifc.stall) begin
                        void'(exp_q.pop_front());
                        accepted++;
                    end
                end
            end else if (ifc.busy && last_valid) begin
                check("stall_hold", 32'(dut_iss()), 32'(last_seen));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, 32'(ifc.busy), 0);
        check({tag, "_done"}, 32'(ifc.done), 0);
        check({tag, "_cen"}, 32'(ifc.ROM_CEN), 1);
        check({tag, "_jti"}, {20'd0, ifc.DTFAG_j, ifc.DTFAG_t, ifc.DTFAG_i}, 0);
        check({tag, "_stage"}, 32'(ifc.stage_o), 0);
        check({tag, "_grp"}, 32'(ifc.grp_o), 0);
    endtask

    task automatic start_run(input bit inv_b, input bit with_stall);
        for (int s = 0; s < TW_STAGES; s++)
            for (int c = 0; c < 4096; c++)
                exp_q.push_back(model(s, c, inv_b));
        accepted    = 0;
        cen0_cycles = 0;
        last_valid  = 1'b0;
        ifc.start   = 1'b1;
        ifc.stall   = with_stall;
`ifdef DTFAG_SEQ_INV_EN
        ifc.inv     = inv_b;
`endif
        tick();
        ifc.start = 1'b0;
`ifdef DTFAG_SEQ_INV_EN
        ifc.inv   = ~inv_b;
`endif
        check("start_edge_cen", 32'(ifc.ROM_CEN), 1);
        check("start_edge_busy", 32'(ifc.busy), 0);
        if (with_stall) begin
            tick();
            tick();
            check("deferred_cen", 32'(ifc.ROM_CEN), 1);
            check("deferred_busy", 32'(ifc.busy), 0);
            ifc.stall = 1'b0;
        end else begin
            tick();
            check("first_issue_cen", 32'(ifc.ROM_CEN), 0);
            check("first_issue_busy", 32'(ifc.busy), 1);
        end
    endtask

    task automatic run_to_done(input bit rnd_stall, input bit mid_start, input bit dir_stall,
                               input bit do_rst);
        bit seen_done = 1'b0;
        bit did_stall = 1'b0;
        for (int n = 0; n < 20000 && !seen_done; n++) begin
            tick();
            if (ifc.done) begin
                seen_done = 1'b1;
                ifc.stall = 1'b0;
                ifc.start = 1'b0;
            end else if (do_rst && ifc.stage_o == 2'd2 && ifc.grp_o == 12'h800 && !ifc.ROM_CEN) begin
                rst       = 1'b1;
                ifc.stall = 1'b0;
                tick();
                rst = 1'b0;
                exp_q.delete();
                last_valid = 1'b0;
                check_reset_vals("mid_rst");
                tick();
                check("mid_rst_no_done", 32'(ifc.done), 0);
                check("mid_rst_idle_cen", 32'(ifc.ROM_CEN), 1);
                return;
            end else if (dir_stall && !did_stall && ifc.stage_o == 2'd1 && ifc.grp_o == 12'h0FF
                         && !ifc.ROM_CEN) begin
                did_stall = 1'b1;
                ifc.stall = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    check("dir_stall_cen", 32'(ifc.ROM_CEN), 1);
                    check("dir_stall_grp", 32'(ifc.grp_o), 32'h0FF);
                end
                ifc.stall = 1'b0;
                tick();
                check("reissue_cen", 32'(ifc.ROM_CEN), 0);
                check("reissue_grp", 32'(ifc.grp_o), 32'h0FF);
                tick();
                check("next_grp", 32'(ifc.grp_o), 32'h100);
            end else begin
                ifc.stall = rnd_stall ? ($urandom_range(7) == 0) : 1'b0;
                ifc.start = mid_start ? ($urandom_range(300) == 0) : 1'b0;
            end
        end
        ifc.start = 1'b0;
        ifc.stall = 1'b0;
        check("done_seen", 32'(seen_done), 1);
        check("done_busy", 32'(ifc.busy), 0);
        check("done_cen", 32'(ifc.ROM_CEN), 1);
        check("accepted", 32'(accepted), 12288);
        check("queue_empty", 32'(exp_q.size()), 0);
        if (!rnd_stall && !dir_stall) check("cen0_cycles", 32'(cen0_cycles), 12288);
        tick();
        check("done_one_cycle", 32'(ifc.done), 0);
        check("after_busy", 32'(ifc.busy), 0);
        check("after_cen", 32'(ifc.ROM_CEN), 1);
    endtask

    initial begin
        bit inv_a;
        bit inv_d;
        ifc.start = 1'b0;
        ifc.stall = 1'b0;
`ifdef DTFAG_SEQ_INV_EN
        ifc.inv   = 1'b0;
        inv_a     = 1'($urandom_range(1));
        inv_d     = 1'b1;
`else
        inv_a     = 1'b0;
        inv_d     = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst = 1'b0;
        tick();
        check("idle_cen", 32'(ifc.ROM_CEN), 1);
        ifc.stall = 1'b1;
        tick();
        tick();
        check("idle_stall_busy", 32'(ifc.busy), 0);
        check("idle_stall_cen", 32'(ifc.ROM_CEN), 1);
        ifc.stall = 1'b0;
        mon_en = 1'b1;

        start_run(inv_a, 1'b0);
        run_to_done(1'b1, 1'b1, 1'b0, 1'b0);

        start_run(1'b0, 1'b1);
        run_to_done(1'b0, 1'b0, 1'b1, 1'b0);

        start_run(1'b0, 1'b0);
        run_to_done(1'b0, 1'b0, 1'b0, 1'b1);

        start_run(inv_d, 1'b0);
        run_to_done(1'b0, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
